// File: rtl/uart_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio_if
//  Description : CPU-side bus bundle for the memory-mapped UART: chip
//                selects, read/write strobes and the 32-bit data paths.
//                The master modport is the CPU/decoder side and the slave
//                modport is the peripheral side.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_mmio_if;
   logic        CE_UART;     // data register select (0x500)
   logic        CE_SR;       // status register select (0x504)
   logic        UART_WR;     // write strobe
   logic        UART_RD;     // read strobe
   logic [31:0] WriteData;   // CPU store data, [7:0] used
   logic [31:0] ReadData;    // combinational read data

   modport master (
      output CE_UART,
      output CE_SR,
      output UART_WR,
      output UART_RD,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  CE_UART,
      input  CE_SR,
      input  UART_WR,
      input  UART_RD,
      input  WriteData,
      output ReadData
   );
endinterface
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mmio
//  Description : Memory-mapped 8N1 UART. Write to the data register queues
//                a byte for transmission, read of the data register pops the
//                received byte, read of the status register returns
//                {FRAME_ERR, OVERRUN, TX_BUSY, TX_READY, RX_VALID} and clears
//                the two error flags. Baud-timed TX FSM, mid-bit sampling RX
//                FSM behind a 2-flop synchronizer.
//  Options     : UART_TX_FIFO_EN defined   -> TX buffer is a TX_FIFO_DEPTH
//                                             entry circular FIFO
//                UART_TX_FIFO_EN undefined -> single-byte holding register
//  Revision    : 1.0  initial release
// ============================================================================
module uart_mmio #(
   parameter int CLKS_PER_BIT  = 868,   // clocks per UART bit, 4 or more
   parameter int TX_FIFO_DEPTH = 8      // power of two, FIFO build only
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   uart_mmio_if.slave   bus,
   output logic         TxD,
   input  wire logic    RxD
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int             c_cw        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [c_cw-1:0] c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
   localparam logic [c_cw-1:0] c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_cw-1:0] c_cnt_zero  = '0;
   localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // -------------------------------------------------------------------------
   // Bus decode
   // -------------------------------------------------------------------------
   logic w_data_wr;
   logic w_data_rd;
   logic w_sr_rd;
   logic w_unused;

   assign w_data_wr = bus.CE_UART & bus.UART_WR;
   assign w_data_rd = bus.CE_UART & bus.UART_RD;
   assign w_sr_rd   = bus.CE_SR   & bus.UART_RD;
   assign w_unused  = ^bus.WriteData[31:8];

   // -------------------------------------------------------------------------
   // TX buffer (FIFO or single holding register)
   // -------------------------------------------------------------------------
   logic       w_buf_full;
   logic       w_buf_empty;
   logic [7:0] w_buf_data;
   logic       w_tx_push;
   logic       w_tx_pop;

   // Fullness is judged before any same-cycle pop, so a write into a full
   // buffer is dropped even if the transmitter frees a slot on that edge.
   assign w_tx_push = w_data_wr & ~w_buf_full;

`ifdef UART_TX_FIFO_EN
   localparam int c_aw = $clog2(TX_FIFO_DEPTH);

   logic [7:0]  r_fifo [TX_FIFO_DEPTH];
   logic [c_aw:0] r_wptr;
   logic [c_aw:0] r_rptr;

   // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
   assign w_buf_empty = (r_wptr == r_rptr);
   assign w_buf_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                        (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
   assign w_buf_data  = r_fifo[r_rptr[c_aw-1:0]];

   // FIFO storage: written on accepted pushes, never reset.
   always_ff @(posedge clk) begin
      if (w_tx_push) begin
         r_fifo[r_wptr[c_aw-1:0]] <= bus.WriteData[7:0];
      end
   end

   // Wrapping read/write pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_tx_push) begin
            r_wptr <= r_wptr + (c_aw+1)'(1);
         end
         if (w_tx_pop) begin
            r_rptr <= r_rptr + (c_aw+1)'(1);
         end
      end
   end
`else
   localparam int c_unused_depth = TX_FIFO_DEPTH;

   logic       r_hold_valid;
   logic [7:0] r_hold_data;

   assign w_buf_empty = ~r_hold_valid;
   assign w_buf_full  = r_hold_valid;
   assign w_buf_data  = r_hold_data;

   // Single-byte holding register; push and pop are mutually exclusive
   // because push needs it empty and pop needs it full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= 8'h00;
      end else if (w_tx_push) begin
         r_hold_valid <= 1'b1;
         r_hold_data  <= bus.WriteData[7:0];
      end else if (w_tx_pop) begin
         r_hold_valid <= 1'b0;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Transmitter
   // -------------------------------------------------------------------------
   tx_state_t       r_tx_state;
   logic [c_cw-1:0] r_tx_cnt;
   logic [7:0]      r_tx_shift;
   logic [2:0]      r_tx_bit;
   logic            r_txd;

   // A byte leaves the buffer when a new frame begins: from IDLE, or straight
   // out of the last cycle of a stop bit for gap-free back-to-back frames.
   assign w_tx_pop = ~w_buf_empty &
                     ((r_tx_state == TX_IDLE) ||
                      ((r_tx_state == TX_STOP) && (r_tx_cnt == c_cnt_zero)));

   assign TxD = r_txd;

   // TX FSM: each line state held for CLKS_PER_BIT cycles by a down-counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= c_cnt_zero;
         r_tx_shift <= 8'h00;
         r_tx_bit   <= 3'd0;
         r_txd      <= 1'b1;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               r_txd <= 1'b1;
               if (!w_buf_empty) begin
                  r_tx_state <= TX_START;
                  r_tx_cnt   <= c_bit_last;
                  r_tx_shift <= w_buf_data;
                  r_txd      <= 1'b0;
               end
            end
            TX_START: begin
               if (r_tx_cnt == c_cnt_zero) begin
                  r_tx_state <= TX_DATA;
                  r_tx_cnt   <= c_bit_last;
                  r_tx_bit   <= 3'd0;
                  r_txd      <= r_tx_shift[0];
               end else begin
                  r_tx_cnt <= r_tx_cnt - c_cnt_one;
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == c_cnt_zero) begin
                  r_tx_cnt <= c_bit_last;
                  if (r_tx_bit == 3'd7) begin
                     r_tx_state <= TX_STOP;
                     r_txd      <= 1'b1;
                  end else begin
                     r_tx_bit   <= r_tx_bit + 3'd1;
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                     r_txd      <= r_tx_shift[1];
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt - c_cnt_one;
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == c_cnt_zero) begin
                  if (!w_buf_empty) begin
                     r_tx_state <= TX_START;
                     r_tx_cnt   <= c_bit_last;
                     r_tx_shift <= w_buf_data;
                     r_txd      <= 1'b0;
                  end else begin
                     r_tx_state <= TX_IDLE;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt - c_cnt_one;
               end
            end
            default: begin
               r_tx_state <= TX_IDLE;
               r_txd      <= 1'b1;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Receiver
   // -------------------------------------------------------------------------
   logic            r_rx_s1;
   logic            r_rx_s2;
   logic            r_rx_s3;
   rx_state_t       r_rx_state;
   logic [c_cw-1:0] r_rx_cnt;
   logic [7:0]      r_rx_shift;
   logic [2:0]      r_rx_bit;
   logic            r_rx_commit;
   logic            r_rx_stop_bit;

   // Two-flop synchronizer plus one history flop for falling-edge detection;
   // all idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= RxD;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   // RX FSM: half-bit wait to centre on the start bit, then whole-bit steps.
   // The stop sample is handed to the flag logic one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_state    <= RX_IDLE;
         r_rx_cnt      <= c_cnt_zero;
         r_rx_shift    <= 8'h00;
         r_rx_bit      <= 3'd0;
         r_rx_commit   <= 1'b0;
         r_rx_stop_bit <= 1'b0;
      end else begin
         r_rx_commit <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_s3 && !r_rx_s2) begin
                  r_rx_state <= RX_START;
                  r_rx_cnt   <= c_half_last;
               end
            end
            RX_START: begin
               if (r_rx_cnt == c_cnt_zero) begin
                  if (r_rx_s2) begin
                     r_rx_state <= RX_IDLE;        // glitch, not a start bit
                  end else begin
                     r_rx_state <= RX_DATA;
                     r_rx_cnt   <= c_bit_last;
                     r_rx_bit   <= 3'd0;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt - c_cnt_one;
               end
            end
            RX_DATA: begin
               if (r_rx_cnt == c_cnt_zero) begin
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                  r_rx_cnt   <= c_bit_last;
                  if (r_rx_bit == 3'd7) begin
                     r_rx_state <= RX_STOP;
                  end else begin
                     r_rx_bit <= r_rx_bit + 3'd1;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt - c_cnt_one;
               end
            end
            RX_STOP: begin
               if (r_rx_cnt == c_cnt_zero) begin
                  r_rx_commit   <= 1'b1;
                  r_rx_stop_bit <= r_rx_s2;
                  r_rx_state    <= RX_IDLE;
               end else begin
                  r_rx_cnt <= r_rx_cnt - c_cnt_one;
               end
            end
            default: begin
               r_rx_state <= RX_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // RX data register and sticky flags
   // -------------------------------------------------------------------------
   logic       r_rx_valid;
   logic [7:0] r_rx_data;
   logic       r_overrun;
   logic       r_frame_err;

   // Clears from CPU reads come first so a same-cycle set overrides them; a
   // byte arriving while the old one is popped replaces it without overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_data_rd) begin
            r_rx_valid <= 1'b0;
         end
         if (w_sr_rd) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
         end
         if (r_rx_commit) begin
            if (r_rx_stop_bit) begin
               if (!r_rx_valid || w_data_rd) begin
                  r_rx_data  <= r_rx_shift;
                  r_rx_valid <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
            end else begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read mux
   // -------------------------------------------------------------------------
   logic [4:0] w_status;

   assign w_status = {r_frame_err,
                      r_overrun,
                      (r_tx_state != TX_IDLE) | ~w_buf_empty,
                      ~w_buf_full,
                      r_rx_valid};

   // Zero-latency read data, zero whenever no read strobe is active.
   always_comb begin
      bus.ReadData = 32'h0000_0000;
      if (w_data_rd) begin
         bus.ReadData = {24'h00_0000, r_rx_data};
      end else if (w_sr_rd) begin
         bus.ReadData = {27'h000_0000, w_status};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mmio
//  Description : Directed self-checking bench for uart_mmio at
//                CLKS_PER_BIT=4: reset state, TX frame shape, TX buffering,
//                RX data/overrun/framing/false-start, reset mid-frame.
//                Follows UART_TX_FIFO_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_mmio;

   localparam int c_cpb = 4;

   logic clk;
   logic rst_n;
   logic TxD;
   logic RxD;

   int n_vec;
   int n_miscmp;

   uart_mmio_if bus ();

   uart_mmio #(
      .CLKS_PER_BIT  (c_cpb),
      .TX_FIFO_DEPTH (8)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .TxD   (TxD),
      .RxD   (RxD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic check_vec(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.CE_UART   = 1'b0;
      bus.CE_SR     = 1'b0;
      bus.UART_WR   = 1'b0;
      bus.UART_RD   = 1'b0;
      bus.WriteData = 32'h0;
   endtask

   task automatic cpu_write(input logic [7:0] b);
      @(negedge clk);
      bus.CE_UART   = 1'b1;
      bus.UART_WR   = 1'b1;
      bus.WriteData = {24'hDEAD_BE, b};
      @(negedge clk);
      bus_idle();
   endtask

   task automatic cpu_read(input logic sel_sr, output logic [31:0] d);
      @(negedge clk);
      if (sel_sr) bus.CE_SR = 1'b1;
      else        bus.CE_UART = 1'b1;
      bus.UART_RD = 1'b1;
      #1;
      d = bus.ReadData;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic read_check(input string tag, input logic sel_sr,
                             input logic [31:0] exp);
      logic [31:0] d;
      cpu_read(sel_sr, d);
      check_vec(tag, d, exp);
   endtask

   // Serial frame into RxD, each bit held c_cpb cycles, then idle margin.
   task automatic send_rx(input logic [7:0] b, input logic stopb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         RxD = fr[k];
         repeat (c_cpb - 1) @(negedge clk);
      end
      @(negedge clk);
      RxD = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Wait (bounded) for a start bit on TxD, then decode one frame mid-bit.
   task automatic capture_frame(input int limit, output logic found,
                                output logic [7:0] data, output logic stopb,
                                output int gap);
      gap   = 0;
      found = 1'b0;
      data  = 8'h00;
      stopb = 1'b0;
      do begin
         @(negedge clk);
         gap++;
      end while (TxD !== 1'b0 && gap < limit);
      if (TxD !== 1'b0) return;
      found = 1'b1;
      repeat (c_cpb / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         repeat (c_cpb) @(negedge clk);
         data[k] = TxD;
      end
      repeat (c_cpb) @(negedge clk);
      stopb = TxD;
   endtask

   initial begin
      logic [9:0]  frame;
      logic        found;
      logic [7:0]  data;
      logic        stopb;
      int          gap;
      int          lows;

      n_vec    = 0;
      n_miscmp = 0;
      rst_n    = 1'b0;
      RxD      = 1'b1;
      bus_idle();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // ---------------- reset state ----------------
      check_vec("rst_txd", {31'h0, TxD}, 32'h1);
      check_vec("rst_rd_idle", bus.ReadData, 32'h0);
      read_check("rst_status", 1'b1, 32'h02);
      read_check("rst_data", 1'b0, 32'h00);

      // ---------------- single TX frame 0xA5 ----------------
      cpu_write(8'hA5);
      check_vec("tx_pre_start", {31'h0, TxD}, 32'h1);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < c_cpb; c++) begin
            @(negedge clk);
            bus_idle();
            check_vec($sformatf("tx_bit%0d_c%0d", i, c), {31'h0, TxD},
                      {31'h0, frame[i]});
            if (i == 5 && c == 0) begin
               bus.CE_SR   = 1'b1;
               bus.UART_RD = 1'b1;
               #1;
               check_vec("tx_busy_mid", bus.ReadData, 32'h06);
            end
         end
      end
      bus_idle();
      read_check("tx_done_status", 1'b1, 32'h02);

      // ---------------- TX buffering ----------------
`ifdef UART_TX_FIFO_EN
      fork
         begin
            for (int f = 0; f < 10; f++) begin
               capture_frame(60, found, data, stopb, gap);
               if (f < 9) begin
                  check_vec($sformatf("fifo_found%0d", f), {31'h0, found}, 32'h1);
                  check_vec($sformatf("fifo_data%0d", f), {24'h0, data}, f);
                  check_vec($sformatf("fifo_stop%0d", f), {31'h0, stopb}, 32'h1);
                  if (f >= 1)
                     check_vec($sformatf("fifo_gap%0d", f), gap, 32'd2);
               end else begin
                  check_vec("fifo_9th_dropped", {31'h0, found}, 32'h0);
               end
            end
         end
         begin
            cpu_write(8'h00);
            repeat (2) @(negedge clk);
            for (int j = 1; j <= 9; j++) begin
               @(negedge clk);
               bus.CE_UART   = 1'b1;
               bus.UART_WR   = 1'b1;
               bus.WriteData = j;
            end
            @(negedge clk);
            bus_idle();
            read_check("fifo_full_status", 1'b1, 32'h04);
         end
      join
`else
      fork
         begin
            capture_frame(60, found, data, stopb, gap);
            check_vec("hold_found0", {31'h0, found}, 32'h1);
            check_vec("hold_data0", {24'h0, data}, 32'h11);
            check_vec("hold_stop0", {31'h0, stopb}, 32'h1);
            capture_frame(60, found, data, stopb, gap);
            check_vec("hold_found1", {31'h0, found}, 32'h1);
            check_vec("hold_data1", {24'h0, data}, 32'h22);
            check_vec("hold_gap1", gap, 32'd2);
            capture_frame(60, found, data, stopb, gap);
            check_vec("hold_3rd_dropped", {31'h0, found}, 32'h0);
         end
         begin
            cpu_write(8'h11);
            cpu_write(8'h22);
            cpu_write(8'h33);
            read_check("hold_full_status", 1'b1, 32'h04);
         end
      join
`endif
      read_check("tx_buf_idle_status", 1'b1, 32'h02);

      // ---------------- RX basic ----------------
      send_rx(8'h3C, 1'b1);
      check_vec("rx_rd_idle", bus.ReadData, 32'h0);
      read_check("rx_valid_status", 1'b1, 32'h03);
      read_check("rx_data_3c", 1'b0, 32'h0000003C);
      read_check("rx_cleared_status", 1'b1, 32'h02);

      // ---------------- RX overrun ----------------
      send_rx(8'h5A, 1'b1);
      send_rx(8'h99, 1'b1);
      read_check("ovr_status", 1'b1, 32'h0B);
      read_check("ovr_cleared", 1'b1, 32'h03);
      read_check("ovr_old_data", 1'b0, 32'h5A);
      read_check("ovr_after_pop", 1'b1, 32'h02);

      // ---------------- RX framing error ----------------
      send_rx(8'h44, 1'b1);
      send_rx(8'h77, 1'b0);
      read_check("ferr_status", 1'b1, 32'h13);
      read_check("ferr_cleared", 1'b1, 32'h03);
      read_check("ferr_kept_data", 1'b0, 32'h44);
      read_check("ferr_after_pop", 1'b1, 32'h02);

      // ---------------- RX false start, then re-armed ----------------
      @(negedge clk);
      RxD = 1'b0;
      @(negedge clk);
      RxD = 1'b1;
      repeat (10) @(negedge clk);
      read_check("glitch_status", 1'b1, 32'h02);
      send_rx(8'hC3, 1'b1);
      read_check("rearm_data", 1'b0, 32'hC3);
      read_check("rearm_status", 1'b1, 32'h02);

      // ---------------- reset mid TX frame ----------------
      cpu_write(8'h00);
      repeat (8) @(negedge clk);
      check_vec("rst_mid_pre", {31'h0, TxD}, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check_vec("rst_mid_txd", {31'h0, TxD}, 32'h1);
      rst_n = 1'b1;
      read_check("rst_mid_status", 1'b1, 32'h02);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1) lows++;
      end
      check_vec("rst_mid_no_frame", lows, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

endmodule
`default_nettype wire
